// File: rtl/demux_stream_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
package demux_stream_pkg;
  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;
endpackage

// File: rtl/stream_slot.sv
// One-entry output register for a single stream channel: load, drain or hold.
module stream_slot #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A load in the same cycle as a drain wins, giving full-rate pass-through.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 valid/ready stream demultiplexer; each channel has its own one-entry slot.
module demux_1_4_stream
  import demux_stream_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  ch_sel_t          in_sel,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic [W-1:0]     out_data0,
  output logic [W-1:0]     out_data1,
  output logic [W-1:0]     out_data2,
  output logic [W-1:0]     out_data3,
  output logic [CNT_W-1:0] in_count,
  output logic             busy
);

  logic [N_CH-1:0] load;
  logic [W-1:0]    slot_data [N_CH];
  logic            accept;
  logic [CNT_W-1:0] in_count_q, in_count_d;

  // Only the addressed channel can stall the producer.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign load[i] = accept && (in_sel == ch_sel_t'(i));

    stream_slot #(
      .W(W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_data (in_data),
      .ready     (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (slot_data[i])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

  always_comb begin
    in_count_d = in_count_q;
    if (accept) begin
      in_count_d = in_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_count_q <= '0;
    end else begin
      in_count_q <= in_count_d;
    end
  end

  assign in_count = in_count_q;
  assign busy     = |out_valid;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: directed steps plus random traffic vs a reference model.
module tb_demux_1_4_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [7:0] in_count;
  logic       busy;

  int tests;
  int fails;

  // Reference model: per-channel "holds a word" flag, held word, accepted count.
  logic       m_full [4];
  logic [3:0] m_word [4];
  logic [7:0] m_count;

  demux_1_4_stream #(
    .W     (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .in_count  (in_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_word[i] = 4'h0;
    end
    m_count = 8'd0;
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] exp_valid;
    for (int i = 0; i < 4; i++) exp_valid[i] = m_full[i];
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({tag, ".out_data0"}, 32'(out_data0), 32'(m_word[0]));
    check({tag, ".out_data1"}, 32'(out_data1), 32'(m_word[1]));
    check({tag, ".out_data2"}, 32'(out_data2), 32'(m_word[2]));
    check({tag, ".out_data3"}, 32'(out_data3), 32'(m_word[3]));
    check({tag, ".in_count"}, 32'(in_count), 32'(m_count));
    check({tag, ".busy"}, 32'(busy), 32'(exp_valid != 4'b0000));
  endtask

  // One clock cycle: drive, check in_ready before the edge, update model, check after the edge.
  task automatic cycle(input string tag, input logic v, input logic [3:0] d,
                       input logic [1:0] sel, input logic [3:0] rdy);
    logic exp_ready;
    logic acc;
    in_valid  = v;
    in_data   = d;
    in_sel    = sel;
    out_ready = rdy;
    #2;
    exp_ready = !m_full[sel] || rdy[sel];
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (acc && sel == 2'(i)) begin
        m_full[i] = 1'b1;
        m_word[i] = d;
      end else if (m_full[i] && rdy[i]) begin
        m_full[i] = 1'b0;
      end
    end
    if (acc) m_count = m_count + 8'd1;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] start_count;
    tests = 0;
    fails = 0;
    model_reset();

    // Reset held for 3 cycles with a word offered.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'hF;
    in_sel    = 2'd1;
    out_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("first", 1'b1, 4'h3, 2'd0, 4'b0001);
    check("first.out_valid0", 32'(out_valid), 32'h1);
    cycle("drain0", 1'b0, 4'h0, 2'd0, 4'b0001);

    // Single route to channel 2, then held while stalled.
    cycle("route", 1'b1, 4'hA, 2'd2, 4'b0000);
    check("route.valid", 32'(out_valid), 32'h4);
    check("route.data2", 32'(out_data2), 32'hA);
    for (int k = 0; k < 5; k++) cycle("stall", 1'b0, 4'h0, 2'd0, 4'b0000);
    check("stall.data2", 32'(out_data2), 32'hA);

    // Channel 2 full and stalled blocks only words addressed to it.
    cycle("block2", 1'b1, 4'h6, 2'd2, 4'b0000);
    check("block2.data2", 32'(out_data2), 32'hA);
    cycle("iso0", 1'b1, 4'h5, 2'd0, 4'b0000);
    check("iso0.data0", 32'(out_data0), 32'h5);

    // Full-rate pass-through on channel 3.
    for (int k = 1; k <= 8; k++) begin
      cycle("stream3", 1'b1, 4'(k), 2'd3, 4'b1111);
      check("stream3.data3", 32'(out_data3), 32'(k));
      check("stream3.valid3", 32'(out_valid[3]), 32'h1);
    end
    cycle("flush", 1'b0, 4'h0, 2'd0, 4'b1111);

    // Simultaneous load and drain on channel 1.
    cycle("load1", 1'b1, 4'h7, 2'd1, 4'b0000);
    cycle("ld_dr1", 1'b1, 4'h9, 2'd1, 4'b0010);
    check("ld_dr1.valid1", 32'(out_valid[1]), 32'h1);
    check("ld_dr1.data1", 32'(out_data1), 32'h9);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle("rand", 1'($urandom), 4'($urandom), 2'($urandom), 4'($urandom));
    end

    // 256 accepted words bring the counter back around.
    start_count = m_count;
    for (int k = 0; k < 256; k++) begin
      cycle("wrap", 1'b1, 4'($urandom), 2'($urandom), 4'b1111);
    end
    check("wrap.count", 32'(in_count), 32'(start_count));

    // Asynchronous reset dropped between edges clears outputs immediately.
    cycle("pre_rst", 1'b1, 4'hC, 2'd2, 4'b0000);
    cycle("pre_rst", 1'b1, 4'hD, 2'd0, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 4'hE, 2'd3, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
